// File: rtl/seven_segment_scanner_if.sv
// Bus between the board-level controller and the seven-segment scanner.
// The master drives the value to show, and the slave (the scanner) drives the display pins.
interface seven_segment_scanner_if;
  logic        Enable;
  logic [15:0] DataIn;
  logic [3:0]  DpIn;
  logic [3:0]  DigitEnable;
  logic [3:0]  Anodes;
  logic [7:0]  Segments;
  logic        FrameTick;

  modport master (
    output Enable, DataIn, DpIn, DigitEnable,
    input  Anodes, Segments, FrameTick
  );

  modport slave (
    input  Enable, DataIn, DpIn, DigitEnable,
    output Anodes, Segments, FrameTick
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit scanner for the Basys3 display, with a blanking gap before every digit.
// Optional build macro LEADING_ZERO_BLANK_EN turns off leading-zero digits 1..3.
module seven_segment_scanner #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input logic                    Clock,
  input logic                    nReset,
  seven_segment_scanner_if.slave bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE_SHOW = CW'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [0:0]    state;
  logic [3:0]    anodes_q;
  logic [7:0]    segments_q;
  logic          frame_tick_q;

  logic [3:0] nibble;
  logic       dp_sel;
  logic       digit_dark;
  logic [7:0] seg_dec;
  logic [7:0] seg_next;
  logic [3:0] an_next;

  // Active-low {a..g,dp}, with dp off. The caller fills in bit 0.
  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'h03;
      4'h1: decode = 8'h9F;
      4'h2: decode = 8'h25;
      4'h3: decode = 8'h0D;
      4'h4: decode = 8'h99;
      4'h5: decode = 8'h49;
      4'h6: decode = 8'h41;
      4'h7: decode = 8'h1F;
      4'h8: decode = 8'h01;
      4'h9: decode = 8'h09;
      4'hA: decode = 8'h11;
      4'hB: decode = 8'hC1;
      4'hC: decode = 8'h63;
      4'hD: decode = 8'h85;
      4'hE: decode = 8'h61;
      default: decode = 8'h71;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a value at the top. If any path skipped an assignment, synthesis would infer a latch.
    nibble     = bus.DataIn[{idx, 2'b00} +: 4];
    dp_sel     = bus.DpIn[idx];
    digit_dark = ~bus.DigitEnable[idx];
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx != 2'd0) && !dp_sel && ((bus.DataIn >> {idx, 2'b00}) == 16'h0000))
      digit_dark = 1'b1;
`endif
    seg_dec  = decode(nibble);
    seg_next = digit_dark ? 8'hFF : {seg_dec[7:1], ~dp_sel};
    an_next  = digit_dark ? 4'b1111 : ~(4'b0001 << idx);
  end

  // NOTE: the reset is asynchronous. The outputs go dark as soon as nReset falls, and do not wait for a clock edge.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      // NOTE: sequential state is assigned with <= only, so all registers update together at the clock edge.
      cnt          <= '0;
      idx          <= 2'd0;
      state        <= ST_BLANK;
      anodes_q     <= 4'b1111;
      segments_q   <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else if (!bus.Enable) begin
      cnt          <= '0;
      idx          <= 2'd0;
      state        <= ST_BLANK;
      anodes_q     <= 4'b1111;
      segments_q   <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      if (cnt == CNT_LAST) begin
        cnt          <= '0;
        idx          <= idx + 2'd1;
        state        <= ST_BLANK;
        anodes_q     <= 4'b1111;
        segments_q   <= 8'hFF;
        frame_tick_q <= (idx == 2'd3);
      end else begin
        cnt <= cnt + 1'b1;
        // The digit snapshot is taken only here, so DataIn can change mid-slot without disturbing the lit digit.
        if (cnt == CNT_PRE_SHOW) begin
          state      <= ST_SHOW;
          anodes_q   <= an_next;
          segments_q <= seg_next;
        end
      end
    end
  end

  // Gating with the state keeps the pins dark during BLANK, whatever the snapshot registers hold.
  assign bus.Anodes    = (state == ST_SHOW) ? anodes_q   : 4'b1111;
  assign bus.Segments  = (state == ST_SHOW) ? segments_q : 8'hFF;
  assign bus.FrameTick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with TICK_DIV=8 and BLANK_CYCLES=2 (8-cycle slots, 32-cycle frames).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seven_segment_scanner;

  localparam int TICK_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic Clock  = 1'b0;
  logic nReset = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  seven_segment_scanner_if bus ();

  seven_segment_scanner #(
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .Clock (Clock),
    .nReset(nReset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [3:0] an, input logic [7:0] seg);
    check({tag, ".anodes"}, {12'h0, bus.Anodes}, {12'h0, an});
    check({tag, ".segments"}, {8'h0, bus.Segments}, {8'h0, seg});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    int ft_cnt;
    int lit0_cnt;
    int multi_cnt;

    bus.Enable      = 1'b1;
    bus.DataIn      = 16'h1234;
    bus.DpIn        = 4'b0000;
    bus.DigitEnable = 4'b1111;

    // Held in reset while the clock runs
    tick(3);
    check_disp("reset", 4'b1111, 8'hFF);
    check("reset.frametick", {15'h0, bus.FrameTick}, 16'h0);

    // Release: p counts rising edges since release
    nReset = 1'b1;
    check_disp("p0_blank", 4'b1111, 8'hFF);
    tick(1);
    check_disp("p1_blank", 4'b1111, 8'hFF);
    tick(1);
    check_disp("p2_digit0", 4'b1110, 8'h99);
    tick(5);
    check_disp("p7_digit0_last", 4'b1110, 8'h99);
    tick(1);
    check_disp("p8_slot1_blank", 4'b1111, 8'hFF);
    check("p8_no_tick", {15'h0, bus.FrameTick}, 16'h0);
    tick(2);
    check_disp("p10_digit1", 4'b1101, 8'h0D);
    tick(8);
    check_disp("p18_digit2", 4'b1011, 8'h25);
    tick(8);
    check_disp("p26_digit3", 4'b0111, 8'h9F);
    tick(6);
    check("p32_frametick", {15'h0, bus.FrameTick}, 16'h1);
    check_disp("p32_blank", 4'b1111, 8'hFF);
    tick(1);
    check("p33_frametick_low", {15'h0, bus.FrameTick}, 16'h0);

    // Two full frames (p=34..97): tick count, digit-0 lit time, one-anode rule
    ft_cnt = 0;
    lit0_cnt = 0;
    multi_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (bus.FrameTick === 1'b1) ft_cnt++;
      if (bus.Anodes === 4'b1110) lit0_cnt++;
      if (!$onehot0(~bus.Anodes)) multi_cnt++;
    end
    check("frametick_count", 16'(ft_cnt), 16'd2);
    check("digit0_lit_cycles", 16'(lit0_cnt), 16'd12);
    check("multi_anode_cycles", 16'(multi_cnt), 16'd0);

    // p=97 (digit 0 blank): decimal point on digit 1 and masking of digit 2
    bus.DataIn      = 16'h8888;
    bus.DpIn        = 4'b0010;
    bus.DigitEnable = 4'b1011;
    tick(1);
    check_disp("dp_digit0", 4'b1110, 8'h01);
    tick(8);
    check_disp("dp_digit1", 4'b1101, 8'h00);
    tick(8);
    check_disp("mask_digit2", 4'b1111, 8'hFF);
    tick(5);
    check_disp("mask_digit2_late", 4'b1111, 8'hFF);
    tick(3);
    check_disp("dp_digit3", 4'b0111, 8'h01);

    // p=122: DataIn changes in the middle of the digit-0 SHOW period
    bus.DataIn      = 16'h0000;
    bus.DpIn        = 4'b0000;
    bus.DigitEnable = 4'b1111;
    tick(8);
    check_disp("mid_p130", 4'b1110, 8'h03);
    tick(2);
    bus.DataIn = 16'h000F;
    tick(1);
    check_disp("mid_p133_held", 4'b1110, 8'h03);
    tick(2);
    check_disp("mid_p135_held", 4'b1110, 8'h03);
    tick(27);
    check_disp("mid_next_slot", 4'b1110, 8'h71);

    // p=162: Enable is dropped during the digit-2 SHOW period
    bus.DataIn = 16'h1234;
    tick(18);
    check_disp("en_digit2_lit", 4'b1011, 8'h25);
    bus.Enable = 1'b0;
    tick(1);
    check_disp("en_off_next_edge", 4'b1111, 8'hFF);
    check("en_off_frametick", {15'h0, bus.FrameTick}, 16'h0);
    tick(5);
    check_disp("en_off_hold", 4'b1111, 8'hFF);
    bus.Enable = 1'b1;
    tick(1);
    check_disp("en_on_q1_blank", 4'b1111, 8'hFF);
    check("en_on_q1_no_tick", {15'h0, bus.FrameTick}, 16'h0);
    tick(1);
    check_disp("en_on_q2_digit0", 4'b1110, 8'h99);
    tick(1);
    check_disp("en_on_q3_digit0", 4'b1110, 8'h99);
    check("en_on_q3_no_tick", {15'h0, bus.FrameTick}, 16'h0);
    tick(29);
    check("en_on_q32_frametick", {15'h0, bus.FrameTick}, 16'h1);

    // Reset asserted mid-SHOW: the outputs must go dark before the next edge
    tick(2);
    check_disp("pre_reset_lit", 4'b1110, 8'h99);
    nReset = 1'b0;
    #1;
    check_disp("async_reset", 4'b1111, 8'hFF);
    check("async_reset_frametick", {15'h0, bus.FrameTick}, 16'h0);
    bus.DataIn = 16'h0005;
    tick(2);
    check_disp("reset_held", 4'b1111, 8'hFF);

    // Leading zeros: dark only when LEADING_ZERO_BLANK_EN is defined
    nReset = 1'b1;
    tick(2);
    check_disp("lz5_digit0", 4'b1110, 8'h49);
    tick(8);
    check_disp("lz5_digit1", LZ ? 4'b1111 : 4'b1101, LZ ? 8'hFF : 8'h03);
    tick(8);
    check_disp("lz5_digit2", LZ ? 4'b1111 : 4'b1011, LZ ? 8'hFF : 8'h03);
    tick(8);
    check_disp("lz5_digit3", LZ ? 4'b1111 : 4'b0111, LZ ? 8'hFF : 8'h03);
    bus.DataIn = 16'h0105;
    tick(8);
    check_disp("lz105_digit0", 4'b1110, 8'h49);
    tick(8);
    check_disp("lz105_digit1", 4'b1101, 8'h03);
    tick(8);
    check_disp("lz105_digit2", 4'b1011, 8'h9F);
    tick(8);
    check_disp("lz105_digit3", LZ ? 4'b1111 : 4'b0111, LZ ? 8'hFF : 8'h03);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
